dm_arbiter: RTL
===============

# dm_arbiter

Sequencer and arbiter for the single-port data memory in the P7 CPU. It shares the memory between the CPU MEM-stage data port (C) and the device/DMA port (D) using round-robin arbitration. It generates the 4-bit byte enable and lane-replicated write data from the address low bits and the access size, and it flags misaligned accesses without touching memory. It replaces the direct MEM-stage→DM connection with a multi-cycle request/done handshake.

## Interface
Parameters:
- MEM_LAT, 1, cycles `m_en` is held per access; read data is sampled on the last of them (≥1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; state clears on the rising edge where reset==0.
- c_req  in  1  CPU request level; held, with fields stable, until c_done.
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  32  byte address.
- c_op  in  2  size: 1 = word, 2 = half, 3 = byte, 0 = invalid.
- c_wdata  in  32  store data, right-aligned.
- c_gnt  out  1  one-cycle pulse when the C request is accepted.
- c_done  out  1  one-cycle completion pulse.
- c_aerr  out  1  valid with c_done; alignment/size error.
- c_rdata  out  32  valid with c_done on loads; addressed lane shifted to bit 0, upper bits zero.
- d_req, d_we, d_addr, d_op, d_wdata, d_gnt, d_done, d_aerr, d_rdata: identical set for port D.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write.
- m_addr  out  32  word address; bits [1:0] are always 0.
- m_be  out  4  byte enable.
- m_wdata  out  32  lane-replicated write data.
- m_rdata  in  32  memory read word.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Arbitration (IDLE only):
  - Only one port requesting: that port wins.
  - Both requesting: the port not in `last` wins.
  - `last` updates on each grant and resets to D, so C wins first.
- On grant, the winner's we/addr/op/wdata and the port id are latched.
- Alignment check:
  - Error if op==0, or op==1 with addr[1:0]≠0, or op==2 with addr[0]≠0.
  - On error: go IDLE→DONE, with m_en kept 0 and aerr=1.
  - Otherwise: go IDLE→ACCESS.
- Byte enable:
  - op 1 → 1111.
  - op 2 → 0011 if addr[1]==0, else 1100.
  - op 3 → 0001/0010/0100/1000 for addr[1:0]=0/1/2/3.
- Write data:
  - word: as-is.
  - half: {2{wdata[15:0]}}.
  - byte: {4{wdata[7:0]}}.
- ACCESS:
  - Hold m_en=1, m_we=latched we, and m_addr/m_be/m_wdata stable for MEM_LAT cycles; a counter runs from MEM_LAT−1 down to 0.
  - On the final cycle, capture m_rdata into an internal register, then go to DONE.
- Read extract: rdata = captured word >> (8·addr[1:0]), masked to 8/16/32 bits by op.
- DONE: assert done for the latched port and, if set, aerr; go to IDLE unconditionally.
- The gnt, done and aerr outputs for the non-owning port stay 0.
- Reset (any state):
  - State returns to IDLE; any in-flight access is dropped with no done.
  - All outputs go to 0, the counter to 0, and `last` to D.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from req to gnt.
- Req sampled high in IDLE at edge T:
  - gnt pulse during cycle T+1.
  - m_en high during cycles T+1 … T+MEM_LAT.
  - done/rdata during cycle T+MEM_LAT+1.
  - IDLE at T+MEM_LAT+2.
- Misaligned request: gnt and done/aerr together during cycle T+1; m_en never rises.
- A req still high in the IDLE cycle after done is treated as a new request. Back-to-back accesses therefore have one IDLE cycle between them.
- Requests arriving in ACCESS or DONE wait; they are never lost or reordered within a port.
- Memory side: m_rdata must be valid at the rising edge ending the last m_en cycle.

## Test plan
- MEM_LAT=1, C store byte, addr 0x0000_1003, wdata 0x0000_00AB → m_addr=0x0000_1000, m_be=1000, m_wdata=0xABAB_ABAB, m_we=1 for 1 cycle; c_done at T+2; c_aerr=0.
- C load half, addr 0x0000_0002, m_rdata=0x1234_5678 → m_be=1100; c_rdata=0x0000_1234 with c_done.
- C and D both requesting continuously from reset → grant order C, D, C, D; no port is granted twice in a row; each done goes only to its owner.
- C load word, addr 0x0000_0006 → c_gnt and c_done with c_aerr=1 at T+1; m_en stays 0; c_op=0 gives the same result.
- MEM_LAT=3, D load word, addr 0x10 → m_en high exactly 3 cycles; d_done at T+4; reset driven low during the 2nd m_en cycle → next cycle IDLE with m_en=0, busy=0, no d_done; then a C+D contention → C granted first.

Source files
------------

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Sequencer and round-robin arbiter for the single-port data memory.
// Two requesters share the memory: the CPU MEM-stage data port (C) and the
// device/DMA port (D). The block builds the byte enable and lane-replicated
// write data from the address low bits and access size, and it flags
// misaligned or invalid-size accesses without touching memory.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   c_req/c_we/c_addr/c_op/c_wdata   CPU request (held until c_done)
//   c_gnt/c_done/c_aerr/c_rdata      CPU grant pulse, completion, error, load data
//   d_*                              same set for the device/DMA port
//   m_en/m_we/m_addr/m_be/m_wdata    memory access (word address, byte lanes)
//   m_rdata                          memory read word, sampled on last m_en cycle
//   busy                             sequencer not idle
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_op,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_done,
    output logic        c_aerr,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_aerr,
    output logic [31:0] d_rdata,

    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // The counter only ever holds MEM_LAT-1 down to 0.
    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Size/alignment error: invalid size, unaligned word, odd half.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] lo);
        logic err_v;
        err_v = 1'b0;
        case (op)
            2'd0:    err_v = 1'b1;
            2'd1:    err_v = (lo != 2'b00);
            2'd2:    err_v = lo[0];
            2'd3:    err_v = 1'b0;
            default: err_v = 1'b1;
        endcase
        return err_v;
    endfunction

    // Byte-lane enable for the addressed bytes.
    function automatic logic [3:0] calc_be(input logic [1:0] op, input logic [1:0] lo);
        logic [3:0] be_v;
        be_v = 4'b0000;
        case (op)
            2'd1:    be_v = 4'b1111;
            2'd2:    be_v = lo[1] ? 4'b1100 : 4'b0011;
            2'd3:    be_v = 4'b0001 << lo;
            default: be_v = 4'b0000;
        endcase
        return be_v;
    endfunction

    // Replicate right-aligned store data across all lanes so the byte
    // enable alone selects where it lands.
    function automatic logic [31:0] calc_wdata(input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] wd_v;
        wd_v = 32'h0000_0000;
        case (op)
            2'd1:    wd_v = wd;
            2'd2:    wd_v = {2{wd[15:0]}};
            2'd3:    wd_v = {4{wd[7:0]}};
            default: wd_v = 32'h0000_0000;
        endcase
        return wd_v;
    endfunction

    // Move the addressed lane down to bit 0 and zero the upper bits.
    function automatic logic [31:0] extract(input logic [1:0] op, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [31:0] sh_v;
        logic [31:0] rd_v;
        sh_v = word >> {lo, 3'b000};
        rd_v = 32'h0000_0000;
        case (op)
            2'd1:    rd_v = sh_v;
            2'd2:    rd_v = {16'h0000, sh_v[15:0]};
            2'd3:    rd_v = {24'h00_0000, sh_v[7:0]};
            default: rd_v = 32'h0000_0000;
        endcase
        return rd_v;
    endfunction

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;
    logic             owner_r;
    logic             we_r;
    logic [1:0]       op_r;
    logic [1:0]       addr_lo_r;
    logic [CNT_W-1:0] cnt_r;

    logic        c_gnt_r, c_done_r, c_aerr_r;
    logic [31:0] c_rdata_r;
    logic        d_gnt_r, d_done_r, d_aerr_r;
    logic [31:0] d_rdata_r;
    logic        m_en_r, m_we_r;
    logic [31:0] m_addr_r, m_wdata_r;
    logic [3:0]  m_be_r;
    logic        busy_r;

    // Arbitration result (only acted on in IDLE)
    logic        req_any_s;
    logic        win_d_s;
    logic        win_we_s;
    logic [31:0] win_addr_s;
    logic [1:0]  win_op_s;
    logic [31:0] win_wdata_s;
    logic        win_err_s;

    assign req_any_s = c_req | d_req;

    // Round-robin winner select and mux of the winning request fields.
    always_comb begin
        win_d_s = 1'b0;
        if (c_req && d_req) begin
            // Both pending: the port that did not win last time goes now.
            win_d_s = (last_r == PORT_C);
        end else if (d_req) begin
            win_d_s = 1'b1;
        end else begin
            win_d_s = 1'b0;
        end
        win_we_s    = win_d_s ? d_we    : c_we;
        win_addr_s  = win_d_s ? d_addr  : c_addr;
        win_op_s    = win_d_s ? d_op    : c_op;
        win_wdata_s = win_d_s ? d_wdata : c_wdata;
        win_err_s   = is_misaligned(win_op_s, win_addr_s[1:0]);
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    // Errored requests skip the memory entirely.
                    state_nxt_s = win_err_s ? ST_DONE : ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: grant latching, memory drive, completion pulses and load data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_r    <= PORT_D;
            owner_r   <= PORT_C;
            we_r      <= 1'b0;
            op_r      <= 2'd0;
            addr_lo_r <= 2'd0;
            cnt_r     <= CNT_ZERO;
            c_gnt_r   <= 1'b0;
            c_done_r  <= 1'b0;
            c_aerr_r  <= 1'b0;
            c_rdata_r <= 32'h0000_0000;
            d_gnt_r   <= 1'b0;
            d_done_r  <= 1'b0;
            d_aerr_r  <= 1'b0;
            d_rdata_r <= 32'h0000_0000;
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= 32'h0000_0000;
            m_be_r    <= 4'b0000;
            m_wdata_r <= 32'h0000_0000;
            busy_r    <= 1'b0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            c_gnt_r   <= 1'b0;
            c_done_r  <= 1'b0;
            c_aerr_r  <= 1'b0;
            c_rdata_r <= 32'h0000_0000;
            d_gnt_r   <= 1'b0;
            d_done_r  <= 1'b0;
            d_aerr_r  <= 1'b0;
            d_rdata_r <= 32'h0000_0000;
            busy_r    <= (state_nxt_s != ST_IDLE);

            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        last_r    <= win_d_s;
                        owner_r   <= win_d_s;
                        we_r      <= win_we_s;
                        op_r      <= win_op_s;
                        addr_lo_r <= win_addr_s[1:0];
                        if (win_d_s) begin
                            d_gnt_r  <= 1'b1;
                            d_done_r <= win_err_s;
                            d_aerr_r <= win_err_s;
                        end else begin
                            c_gnt_r  <= 1'b1;
                            c_done_r <= win_err_s;
                            c_aerr_r <= win_err_s;
                        end
                        if (!win_err_s) begin
                            m_en_r    <= 1'b1;
                            m_we_r    <= win_we_s;
                            m_addr_r  <= {win_addr_s[31:2], 2'b00};
                            m_be_r    <= calc_be(win_op_s, win_addr_s[1:0]);
                            m_wdata_r <= calc_wdata(win_op_s, win_wdata_s);
                            cnt_r     <= CNT_LOAD;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Last m_en cycle: m_rdata is valid on this edge.
                        m_en_r    <= 1'b0;
                        m_we_r    <= 1'b0;
                        m_addr_r  <= 32'h0000_0000;
                        m_be_r    <= 4'b0000;
                        m_wdata_r <= 32'h0000_0000;
                        if (owner_r == PORT_D) begin
                            d_done_r  <= 1'b1;
                            d_rdata_r <= we_r ? 32'h0000_0000 : extract(op_r, addr_lo_r, m_rdata);
                        end else begin
                            c_done_r  <= 1'b1;
                            c_rdata_r <= we_r ? 32'h0000_0000 : extract(op_r, addr_lo_r, m_rdata);
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign c_gnt   = c_gnt_r;
    assign c_done  = c_done_r;
    assign c_aerr  = c_aerr_r;
    assign c_rdata = c_rdata_r;
    assign d_gnt   = d_gnt_r;
    assign d_done  = d_done_r;
    assign d_aerr  = d_aerr_r;
    assign d_rdata = d_rdata_r;
    assign m_en    = m_en_r;
    assign m_we    = m_we_r;
    assign m_addr  = m_addr_r;
    assign m_be    = m_be_r;
    assign m_wdata = m_wdata_r;
    assign busy    = busy_r;

endmodule
